// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   This block answers the core's data-memory port. Reads return in the same
//   cycle, so the core can keep executing one instruction per cycle.
//   Behind the port sit a word-addressed RAM and four memory-mapped registers
//   at the top of the address space:
//     N-4 : TIMER_CNT   free-running 32-bit counter
//     N-3 : TIMER_CMP   compare value
//     N-2 : CTRL/STATUS bit0 timer_en, bit1 auto_reload, bit2 irq_en,
//                       bit8 match_flag (write 1 to clear)
//     N-1 : GPIO        output register
//   Here N = 2**ADDR_WIDTH.
//
// Ports:
//   clk             system clock; all state updates on the rising edge
//   reset           synchronous, active-high reset
//   dmem_write      write strobe; the write commits at the next rising edge
//   dmem_reg        word address
//   dmem_write_data write data
//   dmem_read_data  combinational read data for dmem_reg
//   timer_irq       level interrupt, match_flag & irq_en
//   gpio_out        GPIO register contents
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int GPIO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dmem_write,
    input  logic [ADDR_WIDTH-1:0] dmem_reg,
    input  logic [DATA_WIDTH-1:0] dmem_write_data,
    output logic [DATA_WIDTH-1:0] dmem_read_data,
    output logic                  timer_irq,
    output logic [GPIO_WIDTH-1:0] gpio_out
);

    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int RAM_WORDS = NUM_WORDS - 4;

    localparam logic [ADDR_WIDTH-1:0] ADDR_CNT  = ADDR_WIDTH'(NUM_WORDS - 4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CMP  = ADDR_WIDTH'(NUM_WORDS - 3);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL = ADDR_WIDTH'(NUM_WORDS - 2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_GPIO = ADDR_WIDTH'(NUM_WORDS - 1);

    localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

    // State
    logic [DATA_WIDTH-1:0] r_ram [0:RAM_WORDS-1];
    logic [DATA_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_cmp;
    logic                  r_timer_en;
    logic                  r_auto_reload;
    logic                  r_irq_en;
    logic                  r_match_flag;
    logic [GPIO_WIDTH-1:0] r_gpio;

    // Decode and helper values
    logic                  w_sel_ram;
    logic                  w_wr_ram;
    logic                  w_wr_cnt;
    logic                  w_wr_cmp;
    logic                  w_wr_ctrl;
    logic                  w_wr_gpio;
    logic                  w_match;
    logic [DATA_WIDTH-1:0] w_ctrl_rd;
    logic [DATA_WIDTH-1:0] w_gpio_rd;

    // Everything below the four MMIO words is RAM.
    assign w_sel_ram = (dmem_reg < ADDR_CNT);

    // Any write during reset is dropped, both for RAM and for MMIO.
    assign w_wr_ram  = dmem_write && !reset && w_sel_ram;
    assign w_wr_cnt  = dmem_write && (dmem_reg == ADDR_CNT);
    assign w_wr_cmp  = dmem_write && (dmem_reg == ADDR_CMP);
    assign w_wr_ctrl = dmem_write && (dmem_reg == ADDR_CTRL);
    assign w_wr_gpio = dmem_write && (dmem_reg == ADDR_GPIO);

    // The compare uses the counter value from before this edge. It counts
    // only while the timer is running.
    assign w_match = r_timer_en && (r_cnt == r_cmp);

    assign timer_irq = r_match_flag && r_irq_en;
    assign gpio_out  = r_gpio;

    // CTRL/STATUS and GPIO read images, with the unused bits forced to zero.
    always_comb begin
        w_ctrl_rd    = '0;
        w_ctrl_rd[0] = r_timer_en;
        w_ctrl_rd[1] = r_auto_reload;
        w_ctrl_rd[2] = r_irq_en;
        w_ctrl_rd[8] = r_match_flag;
        w_gpio_rd                 = '0;
        w_gpio_rd[GPIO_WIDTH-1:0] = r_gpio;
    end

    // Zero-latency read mux. A write in the same cycle is not visible yet,
    // so the old contents are returned.
    always_comb begin
        dmem_read_data = '0;
        if (w_sel_ram) begin
            dmem_read_data = r_ram[dmem_reg];
        end else begin
            case (dmem_reg)
                ADDR_CNT:  dmem_read_data = r_cnt;
                ADDR_CMP:  dmem_read_data = r_cmp;
                ADDR_CTRL: dmem_read_data = w_ctrl_rd;
                default:   dmem_read_data = w_gpio_rd;
            endcase
        end
    end

    // RAM has no reset. Its contents stay undefined until software writes them.
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[dmem_reg] <= dmem_write_data;
        end
    end

    // Timer and MMIO registers.
    // A CPU write to the counter beats both increment and reload.
    // When the hardware sets match_flag in the same cycle as a W1C clear,
    // the set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_cmp         <= '1;
            r_timer_en    <= 1'b0;
            r_auto_reload <= 1'b0;
            r_irq_en      <= 1'b0;
            r_match_flag  <= 1'b0;
            r_gpio        <= '0;
        end else begin
            if (w_wr_cnt) begin
                r_cnt <= dmem_write_data;
            end else if (r_timer_en) begin
                if (w_match && r_auto_reload) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end

            if (w_wr_cmp) begin
                r_cmp <= dmem_write_data;
            end

            if (w_wr_ctrl) begin
                r_timer_en    <= dmem_write_data[0];
                r_auto_reload <= dmem_write_data[1];
                r_irq_en      <= dmem_write_data[2];
            end

            if (w_match) begin
                r_match_flag <= 1'b1;
            end else if (w_wr_ctrl && dmem_write_data[8]) begin
                r_match_flag <= 1'b0;
            end

            if (w_wr_gpio) begin
                r_gpio <= dmem_write_data[GPIO_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder with the default parameters
// (32-bit data, 6-bit address, 16-bit GPIO). That gives this map:
//   addresses 0..59 are RAM
//   60 is TIMER_CNT, 61 is TIMER_CMP, 62 is CTRL, 63 is GPIO
//
// Each applyStimulus call is one clock cycle. It drives the inputs just after
// the falling edge, and the checks that follow see the state before the next
// rising edge commits those inputs.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        dmem_write;
    logic [5:0]  dmem_reg;
    logic [31:0] dmem_write_data;
    logic [31:0] dmem_read_data;
    logic        timer_irq;
    logic [15:0] gpio_out;

    int checkCount;
    int failCount;

    dmem_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(6),
        .GPIO_WIDTH(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dmem_write     (dmem_write),
        .dmem_reg       (dmem_reg),
        .dmem_write_data(dmem_write_data),
        .dmem_read_data (dmem_read_data),
        .timer_irq      (timer_irq),
        .gpio_out       (gpio_out)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs after the falling edge.
    task automatic applyStimulus(input logic rst, input logic wr,
                                 input logic [5:0] addr, input logic [31:0] data);
        @(negedge clk);
        reset           = rst;
        dmem_write      = wr;
        dmem_reg        = addr;
        dmem_write_data = data;
        #1;
    endtask

    // Single compare point: count the check and report any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    logic [31:0] arCnt [6];
    logic [31:0] wrapCnt [4];

    initial begin
        checkCount      = 0;
        failCount       = 0;
        reset           = 1'b1;
        dmem_write      = 1'b0;
        dmem_reg        = '0;
        dmem_write_data = '0;

        arCnt   = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        wrapCnt = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};

        // Reset values of the MMIO registers
        applyStimulus(1'b1, 1'b0, 6'd60, 32'h0);
        applyStimulus(1'b0, 1'b0, 6'd60, 32'h0);
        checkOutput("rst_cnt", dmem_read_data, 32'h0);
        applyStimulus(1'b0, 1'b0, 6'd61, 32'h0);
        checkOutput("rst_cmp", dmem_read_data, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 6'd62, 32'h0);
        checkOutput("rst_ctrl", dmem_read_data, 32'h0);
        checkOutput("rst_gpio_out", {16'h0, gpio_out}, 32'h0);
        checkOutput("rst_irq", {31'h0, timer_irq}, 32'h0);
        applyStimulus(1'b0, 1'b0, 6'd63, 32'h0);
        checkOutput("rst_gpio_rd", dmem_read_data, 32'h0);

        // RAM round trip, including a same-cycle read during a write
        applyStimulus(1'b0, 1'b1, 6'd5, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 6'd5, 32'h0);
        checkOutput("ram_rd", dmem_read_data, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, 6'd5, 32'h1);
        checkOutput("ram_old", dmem_read_data, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 6'd5, 32'h0);
        checkOutput("ram_new", dmem_read_data, 32'h1);
        applyStimulus(1'b0, 1'b1, 6'd59, 32'h1234_5678);
        applyStimulus(1'b0, 1'b0, 6'd59, 32'h0);
        checkOutput("ram_top", dmem_read_data, 32'h1234_5678);

        // Compare with auto-reload: cmp=3, CTRL=7, counter starts from 0
        applyStimulus(1'b0, 1'b1, 6'd61, 32'd3);
        applyStimulus(1'b0, 1'b1, 6'd62, 32'h7);
        checkOutput("ctrl_old", dmem_read_data, 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 6'd60, 32'h0);
            checkOutput($sformatf("ar_cnt%0d", i), dmem_read_data, arCnt[i]);
            checkOutput($sformatf("ar_irq%0d", i), {31'h0, timer_irq}, (i >= 4) ? 32'h1 : 32'h0);
        end
        // The counter is now 2 and the flag is set. Clear the flag with W1C.
        applyStimulus(1'b0, 1'b1, 6'd62, 32'h107);
        checkOutput("ctrl_flag", dmem_read_data, 32'h107);
        // The counter is now 3 (a match cycle). A clear here loses to the set.
        applyStimulus(1'b0, 1'b1, 6'd62, 32'h103);
        checkOutput("flag_cleared", dmem_read_data, 32'h007);
        checkOutput("irq_cleared", {31'h0, timer_irq}, 32'h0);
        applyStimulus(1'b0, 1'b0, 6'd62, 32'h0);
        checkOutput("set_beats_clr", dmem_read_data, 32'h103);
        checkOutput("irq_masked", {31'h0, timer_irq}, 32'h0);
        applyStimulus(1'b0, 1'b0, 6'd60, 32'h0);
        checkOutput("reload_cnt", dmem_read_data, 32'h1);

        // Wrap: stop the timer and clear the flag, then set cmp=5 and
        // cnt=FFFFFFFE, then start the timer
        applyStimulus(1'b0, 1'b1, 6'd62, 32'h100);
        applyStimulus(1'b0, 1'b1, 6'd61, 32'd5);
        applyStimulus(1'b0, 1'b1, 6'd60, 32'hFFFF_FFFE);
        applyStimulus(1'b0, 1'b1, 6'd62, 32'h1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 6'd60, 32'h0);
            checkOutput($sformatf("wrap_cnt%0d", i), dmem_read_data, wrapCnt[i]);
        end
        applyStimulus(1'b0, 1'b0, 6'd62, 32'h0);
        checkOutput("wrap_noflag", dmem_read_data, 32'h001);
        // A CPU write to the counter beats the increment
        applyStimulus(1'b0, 1'b1, 6'd60, 32'h100);
        applyStimulus(1'b0, 1'b0, 6'd60, 32'h0);
        checkOutput("wr_beats_inc", dmem_read_data, 32'h100);
        applyStimulus(1'b0, 1'b0, 6'd60, 32'h0);
        checkOutput("inc_after_wr", dmem_read_data, 32'h101);

        // GPIO keeps only the low 16 bits
        applyStimulus(1'b0, 1'b1, 6'd63, 32'hABCD_1234);
        applyStimulus(1'b0, 1'b0, 6'd63, 32'h0);
        checkOutput("gpio_out", {16'h0, gpio_out}, 32'h0000_1234);
        checkOutput("gpio_rd", dmem_read_data, 32'h0000_1234);

        // Reset during a write: the write is dropped and the registers clear
        applyStimulus(1'b1, 1'b1, 6'd63, 32'h55);
        applyStimulus(1'b0, 1'b0, 6'd63, 32'h0);
        checkOutput("rstwr_gpio_out", {16'h0, gpio_out}, 32'h0);
        checkOutput("rstwr_gpio_rd", dmem_read_data, 32'h0);
        applyStimulus(1'b0, 1'b0, 6'd60, 32'h0);
        checkOutput("rstwr_cnt", dmem_read_data, 32'h0);
        applyStimulus(1'b0, 1'b0, 6'd62, 32'h0);
        checkOutput("rstwr_ctrl", dmem_read_data, 32'h0);
        applyStimulus(1'b1, 1'b1, 6'd5, 32'h0000_CAFE);
        applyStimulus(1'b0, 1'b0, 6'd5, 32'h0);
        checkOutput("rstwr_ram", dmem_read_data, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's data-memory port.
- The core drives address, write strobe and write data; this block returns read data combinationally in the same cycle, which keeps single-cycle execution intact.
- Backs a word-addressed RAM and a small memory-mapped peripheral window: a 32-bit compare timer with interrupt, plus a GPIO output register.
- Sits at top level beside the core, on the far end of the core's dmem bus.

Parameters:
- DATA_WIDTH, 32, word width; the timer and all MMIO registers use this width.
- ADDR_WIDTH, 6, word-address width; the block decodes 2^ADDR_WIDTH words.
- GPIO_WIDTH, 16, width of the GPIO output register (must be ≤ DATA_WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- dmem_write  input  1  write strobe; the write commits at the next rising edge.
- dmem_reg  input  ADDR_WIDTH  word address.
- dmem_write_data  input  DATA_WIDTH  write data.
- dmem_read_data  output  DATA_WIDTH  read data; combinational from dmem_reg and current state.
- timer_irq  output  1  level interrupt = match_flag & irq_en.
- gpio_out  output  GPIO_WIDTH  GPIO register contents.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Address map (N = 2^ADDR_WIDTH):
  - 0..N-5: RAM.
  - N-4: TIMER_CNT.
  - N-3: TIMER_CMP.
  - N-2: CTRL/STATUS.
  - N-1: GPIO.
- RAM:
  - Asynchronous read, synchronous write.
  - RAM is not reset; contents are undefined until written.
- Read timing: zero latency. A read of an address being written in the same cycle returns the old value; the new value is visible the cycle after the edge.
- CTRL read:
  - bit0 = timer_en, bit1 = auto_reload, bit2 = irq_en, bit8 = match_flag.
  - All other bits read 0.
- CTRL write:
  - Loads bits[2:0].
  - Writing 1 to bit8 clears match_flag (write-1-to-clear); writing 0 to bit8 has no effect.
- GPIO:
  - Write loads the low GPIO_WIDTH bits.
  - Read returns the value zero-extended to DATA_WIDTH.
- Timer, evaluated each edge when timer_en = 1:
  - match = (cnt == cmp), using the pre-update cnt.
  - On match: match_flag is set, and cnt becomes 0 if auto_reload, else cnt+1.
  - Otherwise: cnt becomes cnt+1.
  - cnt wraps from 0xFFFFFFFF to 0.
  - When timer_en = 0, cnt holds and match is ignored.
- Collision priorities:
  - A CPU write to TIMER_CNT beats increment and reload in the same cycle.
  - A write to TIMER_CMP takes effect from the next cycle's compare.
  - A hardware set of match_flag beats a W1C clear in the same cycle; the flag stays 1.
- Reset values:
  - cnt = 0, cmp = 0xFFFFFFFF, timer_en = auto_reload = irq_en = 0, match_flag = 0, gpio_out = 0, timer_irq = 0.
  - dmem_read_data follows the map: MMIO reads return their reset values; RAM reads are undefined.
- Reset during operation:
  - Any dmem_write in a cycle with reset = 1 is ignored for MMIO registers and RAM.
  - The timer stops, and all registers take their reset values at that edge.
- Out-of-width write data: bits above those defined for CTRL/GPIO are discarded.
- timer_irq is purely combinational from registered state; there is no extra latency beyond the flag register.

Test Plan:
- RAM round trip:
  - Write 0xDEADBEEF to addr 5, then read addr 5 on the next cycle → 0xDEADBEEF.
  - Read addr 5 in the same cycle as a write of 0x1 → old value 0xDEADBEEF; 0x1 the next cycle.
- MMIO reset values:
  - Assert reset for 1 cycle, then read addr 60 → 0.
  - Read addr 61 → 0xFFFFFFFF; read addr 62 → 0; gpio_out = 0; timer_irq = 0.
- Compare with auto-reload:
  - Sequence: cmp = 3, CTRL = 0x7, cnt starts at 0.
  - cnt steps 0, 1, 2, 3, 0, 1.
  - match_flag = 1 and timer_irq = 1 from the edge after cnt = 3.
  - Write CTRL = 0x107 → flag clears the next cycle.
- Wrap and priorities:
  - Wrap: write cnt = 0xFFFFFFFE with CTRL = 0x1 and cmp = 5 → cnt steps 0xFFFFFFFF, 0x0, 0x1 with no flag.
  - Write beats increment: writing cnt = 0x100 while enabled → next read returns 0x100, not 0x101.
- Simultaneous set/clear: write CTRL = 0x103 in the exact cycle cnt == cmp → match_flag reads 1 afterwards.
- GPIO and reset mid-write:
  - Write 0xABCD1234 to addr 63 → gpio_out = 0x1234, and the read returns 0x00001234.
  - Assert reset while writing 0x55 to addr 63 → gpio_out = 0 after the edge.
